// File: rtl/fft_pkg.sv
// Shared types for the sample framing front end of fft_256.
package fft_pkg;

  localparam int WIDTH = 12;
  localparam int N     = 256;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef sample_t [0:N-1]         frame_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } fbuf_state_t;

endpackage

// File: rtl/sample_frame_buffer_if.sv
// Sample stream in, parallel frame plus start/busy handshake out to fft_256.
interface sample_frame_buffer_if #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N
);

  logic signed [WIDTH-1:0]  sample_in;
  logic                     sample_valid;
  logic                     fft_done;
  logic [0:N-1][WIDTH-1:0]  time_samples;
  logic                     fft_start;
  logic                     fft_busy;

  modport master (
    output sample_in,
    output sample_valid,
    output fft_done,
    input  time_samples,
    input  fft_start,
    input  fft_busy
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  fft_done,
    output time_samples,
    output fft_start,
    output fft_busy
  );

endinterface

// File: rtl/sample_frame_buffer_bank.sv
// One N-deep sample bank: indexed write, synchronous clear, full parallel read-out.
module frame_bank #(
  parameter int WIDTH = 12,
  parameter int N     = 256,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    we,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [0:N-1][WIDTH-1:0] rd_data
);

  logic [0:N-1][WIDTH-1:0] mem;

  // Clear wins over write; otherwise store one sample at wr_idx.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem;

endmodule

// File: rtl/sample_frame_buffer.sv
// Ping-pong framer: fills one bank from the sample stream while the other
// bank is held stable for the FFT between fft_start and fft_done.
module sample_frame_buffer #(
  parameter int WIDTH = fft_pkg::WIDTH,
  parameter int N     = fft_pkg::N,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_frame_buffer_if.slave bus,
  output logic                 overflow,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     drop_count
);

  import fft_pkg::*;

  localparam int IDX_W = $clog2(N);

  fbuf_state_t state, state_nxt;

  logic [IDX_W-1:0]        wr_idx;
  logic                    wr_bank;
  logic                    rd_bank;
  logic                    pending;

  logic                    wr_en;
  logic                    complete;
  logic                    frame_ready;
  logic                    handoff;
  logic                    drop;

  logic [0:N-1][WIDTH-1:0] bank0_data;
  logic [0:N-1][WIDTH-1:0] bank1_data;

  // A frame finishing this cycle counts as ready immediately, so hand-off
  // (and fft_start one cycle later) needs no extra pending cycle.
  always_comb begin
    wr_en       = bus.sample_valid && !pending;
    complete    = wr_en && (wr_idx == IDX_W'(N - 1));
    frame_ready = pending || complete;
    handoff     = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE: begin
        if (frame_ready) begin
          handoff   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.fft_done) begin
          if (frame_ready) begin
            handoff   = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    drop = bus.sample_valid && pending && !handoff;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write pointer, bank ownership and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx      <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      pending     <= 1'b0;
      overflow    <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      if (wr_en) begin
        wr_idx <= wr_idx + IDX_W'(1);
      end
      if (handoff) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        pending     <= 1'b0;
        wr_idx      <= '0;
        frame_count <= frame_count + CNT_W'(1);
      end else if (complete) begin
        pending <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
    end
  end

  frame_bank #(
    .WIDTH (WIDTH),
    .N     (N),
    .IDX_W (IDX_W)
  ) u_bank0 (
    .clk     (clk),
    .clr     (rst),
    .we      (wr_en && !wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (bus.sample_in),
    .rd_data (bank0_data)
  );

  frame_bank #(
    .WIDTH (WIDTH),
    .N     (N),
    .IDX_W (IDX_W)
  ) u_bank1 (
    .clk     (clk),
    .clr     (rst),
    .we      (wr_en && wr_bank),
    .wr_idx  (wr_idx),
    .wr_data (bus.sample_in),
    .rd_data (bank1_data)
  );

  assign bus.time_samples = rd_bank ? bank1_data : bank0_data;
  assign bus.fft_start    = (state == START);
  assign bus.fft_busy     = (state != IDLE);

endmodule
